deconvolve: RTL and testbench

//  Inverse of the convolve block: recovers the input signal x from a flattened

---
 rtl/deconvolve.sv | 122 ++++++++++++
 tb/tb_deconvolve.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/deconvolve.sv
// deconvolve: recovers x from y = h * x by sequential back-substitution.
//   x[n] = (y[n] - sum_{k=1..min(n,LEN)} h[k]*x[n-k]) * h0_recip, all Q2.14 signed.
// Ports:
//   clk, rst               clock / synchronous active-high reset
//   load                   start request, accepted in IDLE or DONE
//   flaten_filter_coeff    h[k] at [k*16 +: 16]
//   h0_recip               1/h[0] in Q2.14, supplied by the user
//   flatten_conv_result    y[n] at [n*16 +: 16]; entries above SIGNAL_LENGTH_1 unused
//   flaten_signal          recovered x[n] at [n*16 +: 16]
//   busy                   high from load acceptance until done
//   is_completed           high once every x[n] is valid, until next load or rst
module deconvolve #(
  parameter int LEN             = 19,
  parameter int SIGNAL_LENGTH_1 = 2400
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    load,
  input  logic [(LEN+1)*16-1:0]                   flaten_filter_coeff,
  input  logic [15:0]                             h0_recip,
  input  logic [(LEN+SIGNAL_LENGTH_1+1)*16-1:0]   flatten_conv_result,
  output logic [(SIGNAL_LENGTH_1+1)*16-1:0]       flaten_signal,
  output logic                                    busy,
  output logic                                    is_completed
);

  localparam int NS = SIGNAL_LENGTH_1 + 1;
  localparam int NW = (NS > 1) ? $clog2(NS) : 1;
  localparam int KW = (LEN + 1 > 1) ? $clog2(LEN + 1) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, INIT, MAC, WRITE, DONE} state_t;

  state_t             state;
  logic signed [15:0] h_r [0:LEN];
  logic signed [15:0] y_r [0:SIGNAL_LENGTH_1];
  logic signed [15:0] x_r [0:SIGNAL_LENGTH_1];
  logic signed [15:0] recip_r;
  logic signed [39:0] acc;
  logic [NW-1:0]      n;
  logic [KW-1:0]      k;

  // Datapath helpers
  logic [KW-1:0]      k_last;   // min(n, LEN): last tap used for sample n
  logic [NW-1:0]      xi;       // n - k, never negative since k <= n
  logic signed [31:0] prod;
  logic signed [25:0] acc_sh;   // acc >>> 14 fits 26 bits exactly
  logic signed [41:0] t;
  logic signed [41:0] t_sh;
  logic signed [15:0] x_new;

  always_comb begin
    k_last = (int'(n) > LEN) ? KW'(LEN) : KW'(n);
    xi     = n - NW'(k);
    prod   = h_r[k] * x_r[xi];
    acc_sh = 26'(acc >>> 14);
    t      = acc_sh * recip_r;
    t_sh   = t >>> 14;
    if (t_sh > 42'sd32767)
      x_new = 16'sh7FFF;
    else if (t_sh < -42'sd32768)
      x_new = 16'sh8000;
    else
      x_new = 16'(t_sh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      is_completed  <= 1'b0;
      flaten_signal <= '0;
      recip_r       <= '0;
      acc           <= '0;
      n             <= '0;
      k             <= '0;
      for (int i = 0; i <= LEN; i++) h_r[i] <= '0;
      for (int i = 0; i < NS; i++) begin
        y_r[i] <= '0;
        x_r[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            for (int i = 0; i <= LEN; i++) h_r[i] <= flaten_filter_coeff[i*16 +: 16];
            for (int i = 0; i < NS; i++)   y_r[i] <= flatten_conv_result[i*16 +: 16];
            recip_r      <= h0_recip;
            n            <= '0;
            busy         <= 1'b1;
            is_completed <= 1'b0;
            state        <= LOAD;
          end
        end
        LOAD: state <= INIT;
        INIT: begin
          acc   <= 40'(y_r[n]) << 14;
          k     <= KW'(1);
          state <= (n == '0) ? WRITE : MAC;
        end
        MAC: begin
          acc <= acc - 40'(prod);
          if (k == k_last) state <= WRITE;
          else             k     <= k + KW'(1);
        end
        WRITE: begin
          x_r[n]                         <= x_new;
          flaten_signal[int'(n)*16 +: 16] <= x_new;
          if (n == NW'(SIGNAL_LENGTH_1)) begin
            busy         <= 1'b0;
            is_completed <= 1'b1;
            state        <= DONE;
          end else begin
            n     <= n + NW'(1);
            state <= INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deconvolve.sv
module tb_deconvolve;

  // small instance: LEN=1, SIGNAL_LENGTH_1=3
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] filt = '0;
  logic [15:0] recip = '0;
  logic [79:0] yin = '0;
  logic [63:0] xo;
  logic        busy, done;

  // large instance: default parameters
  localparam int BL = 19;
  localparam int BS = 2400;
  logic                       load_b = 1'b0;
  logic [(BL+1)*16-1:0]       filt_b = '0;
  logic [15:0]                recip_b = '0;
  logic [(BL+BS+1)*16-1:0]    yin_b = '0;
  logic [(BS+1)*16-1:0]       xo_b;
  logic                       busy_b, done_b;

  int nchk = 0;
  int nerr = 0;

  deconvolve #(.LEN(1), .SIGNAL_LENGTH_1(3)) dut (
    .clk(clk), .rst(rst), .load(load), .flaten_filter_coeff(filt),
    .h0_recip(recip), .flatten_conv_result(yin), .flaten_signal(xo),
    .busy(busy), .is_completed(done));

  deconvolve dut_b (
    .clk(clk), .rst(rst), .load(load_b), .flaten_filter_coeff(filt_b),
    .h0_recip(recip_b), .flatten_conv_result(yin_b), .flaten_signal(xo_b),
    .busy(busy_b), .is_completed(done_b));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] h;      // {h1, h0}
    logic [15:0] r;
    logic [79:0] y;      // {y4, y3, y2, y1, y0}
    logic [63:0] x;      // {x3, x2, x1, x0}
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_small(input logic [31:0] h, input logic [15:0] r, input logic [79:0] y);
    @(negedge clk);
    filt = h; recip = r; yin = y; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // edges counted from the accepting edge until is_completed is seen
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  localparam logic [31:0] H_T2 = {16'h2000, 16'h4000};
  localparam logic [79:0] Y_T2 = {16'h0000, 16'h0000, 16'h0800, 16'h2000, 16'h2000};
  localparam logic [63:0] X_T2 = {16'h0000, 16'h0000, 16'h1000, 16'h2000};

  int lat, cnt, busy_drop;
  int xs [0:BS];
  int hs [0:BL];
  int bad;
  longint s;

  initial begin
    vecs[0] = '{"identity", {16'h0000, 16'h4000}, 16'h4000,
                {16'h0000, 16'h7FFF, 16'h0001, 16'hF000, 16'h1234},
                {16'h7FFF, 16'h0001, 16'hF000, 16'h1234}};
    vecs[1] = '{"roundtrip", H_T2, 16'h4000, Y_T2, X_T2};
    vecs[2] = '{"saturate", {16'h0000, 16'h4000}, 16'h7FFF,
                {16'h0000, 16'h0000, 16'h0000, 16'h9000, 16'h7000},
                {16'h0000, 16'h0000, 16'h8000, 16'h7FFF}};
    vecs[3] = '{"recip_zero", {16'h0000, 16'h4000}, 16'h0000,
                {16'h0000, 16'h7FFF, 16'h0001, 16'hF000, 16'h1234}, 64'h0};
    vecs[4] = '{"neg_tap", {16'hC000, 16'h4000}, 16'h4000,
                {16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0100},
                {16'h0110, 16'h0110, 16'h0100, 16'h0100}};
    vecs[5] = '{"trunc_floor", {16'h0000, 16'h4000}, 16'h2000,
                {16'h0000, 16'h0003, 16'hFFFD, 16'h0001, 16'hFFFF},
                {16'h0001, 16'hFFFE, 16'h0000, 16'hFFFF}};

    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_x", xo, 64'h0);

    // table-driven vectors: every run takes 12 edges at LEN=1, SIGNAL_LENGTH_1=3
    for (int i = 0; i < 6; i++) begin
      start_small(vecs[i].h, vecs[i].r, vecs[i].y);
      chk({vecs[i].name, "_busy"}, 64'(busy), 64'd1);
      wait_done(lat);
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'd12);
      chk({vecs[i].name, "_x"}, xo, vecs[i].x);
      if (i == 0) begin
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", 64'(done), 64'd1);
        chk("hold_x", xo, vecs[0].x);
      end
    end

    // load pulse mid-run is ignored
    start_small(H_T2, 16'h4000, Y_T2);
    cnt = 0; busy_drop = 0;
    while (!done && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 2) begin load = 1'b1; yin = {16'h0, 16'h0, 16'h1111, 16'h2222, 16'h3333}; end
      if (cnt == 3) load = 1'b0;
      if (!done && !busy) busy_drop++;
    end
    chk("ignore_lat", 64'(cnt), 64'd12);
    chk("ignore_busy", 64'(busy_drop), 64'd0);
    chk("ignore_x", xo, X_T2);

    // reset in the middle of the n=1 MAC
    start_small(H_T2, 16'h4000, Y_T2);
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_x", xo, 64'h0);
    start_small(H_T2, 16'h4000, Y_T2);
    wait_done(lat);
    chk("after_rst_lat", 64'(lat), 64'd12);
    chk("after_rst_x", xo, X_T2);

    // default parameters: convolve model, then recover
    hs[0] = 16'sh4000;
    for (int k = 1; k <= BL; k++) begin
      case ($urandom_range(0, 2))
        0: hs[k] = -32'sh2000;
        1: hs[k] = 0;
        default: hs[k] = 32'sh2000;
      endcase
    end
    for (int i = 0; i <= BS; i++) xs[i] = (int'($urandom_range(0, 1022)) - 511) * 2;
    for (int k = 0; k <= BL; k++) filt_b[k*16 +: 16] = 16'(hs[k]);
    for (int n = 0; n <= BL + BS; n++) begin
      s = 0;
      for (int k = 0; k <= BL; k++)
        if (n - k >= 0 && n - k <= BS) s += longint'(hs[k]) * longint'(xs[n-k]);
      yin_b[n*16 +: 16] = 16'(s >>> 14);
    end
    recip_b = 16'h4000;
    @(negedge clk);
    load_b = 1'b1;
    @(posedge clk); #1;
    load_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 60000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("big_lat", 64'(lat), 64'd50232);
    bad = 0;
    for (int i = 0; i <= BS; i++) begin
      int d;
      d = int'($signed(xo_b[i*16 +: 16])) - xs[i];
      if (d > 1 || d < -1) bad++;
    end
    chk("big_recover", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
